// File: rtl/fixed_point_alu_accel_master.sv
// Initiator for the fixed-point ALU accel word protocol: serialises {op, a, b} into 5 writes, reads 2 result words.
// Optional cycle counter output resp_cycles enabled by ACCEL_MASTER_CYCLE_COUNT_EN.
module fixed_point_alu_accel_master #(
    parameter int unsigned INTEGER_PART_WIDTH    = 8,
    parameter int unsigned FRACTIONAL_PART_WIDTH = 8
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                req_valid,
    output logic                                                req_ready,
    input  logic [2:0]                                          req_op,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] req_a,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] req_b,
    output logic                                                resp_valid,
    input  logic                                                resp_ready,
    output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] resp_result,
    input  logic                                                accel_can_read,
    input  logic                                                accel_can_write,
    output logic                                                accel_read_enable,
    output logic                                                accel_write_enable,
    input  logic [15:0]                                         accel_read_data,
    output logic [15:0]                                         accel_write_data
`ifdef ACCEL_MASTER_CYCLE_COUNT_EN
    ,
    output logic [15:0]                                         resp_cycles
`endif
);

    localparam int unsigned IPW = INTEGER_PART_WIDTH;
    localparam int unsigned FPW = FRACTIONAL_PART_WIDTH;
    localparam int unsigned NW  = IPW + FPW;
    localparam int unsigned WW  = 16;

    typedef enum logic [3:0] {
        IDLE,
        WR_OP,
        WR_A_INT,
        WR_A_FRAC,
        WR_B_INT,
        WR_B_FRAC,
        RD_INT,
        RD_FRAC,
        RESP
    } state_t;

    state_t        state;
    logic [2:0]    op_q;
    logic [NW-1:0] a_q;
    logic [NW-1:0] b_q;

    // Read words wider than the fields carry don't-care upper bits.
    logic unused_read_bits;
    assign unused_read_bits = ^accel_read_data;

    // Sequencer: request capture, word-by-word handshakes with the responder, result hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        a_q       <= req_a;
                        b_q       <= req_b;
                        req_ready <= 1'b0;
                        state     <= WR_OP;
                    end
                end
                WR_OP:     if (accel_can_write) state <= WR_A_INT;
                WR_A_INT:  if (accel_can_write) state <= WR_A_FRAC;
                WR_A_FRAC: if (accel_can_write) state <= WR_B_INT;
                WR_B_INT:  if (accel_can_write) state <= WR_B_FRAC;
                WR_B_FRAC: if (accel_can_write) state <= RD_INT;
                RD_INT: begin
                    if (accel_can_read) begin
                        resp_result[NW-1-:IPW] <= accel_read_data[IPW-1:0];
                        state                  <= RD_FRAC;
                    end
                end
                RD_FRAC: begin
                    if (accel_can_read) begin
                        resp_result[0+:FPW] <= accel_read_data[FPW-1:0];
                        resp_valid          <= 1'b1;
                        state               <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Enables follow the responder's flow control directly so a word moves in the cycle it is offered.
    always_comb begin
        accel_write_enable = 1'b0;
        accel_read_enable  = 1'b0;
        accel_write_data   = '0;
        case (state)
            WR_OP: begin
                accel_write_enable = accel_can_write;
                accel_write_data   = WW'(op_q);
            end
            WR_A_INT: begin
                accel_write_enable = accel_can_write;
                accel_write_data   = WW'(a_q[NW-1-:IPW]);
            end
            WR_A_FRAC: begin
                accel_write_enable = accel_can_write;
                accel_write_data   = WW'(a_q[0+:FPW]);
            end
            WR_B_INT: begin
                accel_write_enable = accel_can_write;
                accel_write_data   = WW'(b_q[NW-1-:IPW]);
            end
            WR_B_FRAC: begin
                accel_write_enable = accel_can_write;
                accel_write_data   = WW'(b_q[0+:FPW]);
            end
            RD_INT, RD_FRAC: accel_read_enable = accel_can_read;
            default: ;
        endcase
    end

`ifdef ACCEL_MASTER_CYCLE_COUNT_EN
    // Cycles from accept to result, saturating; frozen while the result is presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_cycles <= '0;
        end else if (state == IDLE) begin
            if (req_valid) resp_cycles <= '0;
        end else if (state != RESP && resp_cycles != 16'hFFFF) begin
            resp_cycles <= resp_cycles + 16'd1;
        end
    end
`endif

endmodule
